// File: rtl/stdp_learn.sv
// stdp_learn: pair-based STDP learning block with per-channel spike-age
// timers, age-decayed potentiation/depression and a host weight write port.
module stdp_learn #(
   parameter int N_PRE       = 4,
   parameter int TIMER_W     = 4,
   parameter int WEIGHT_W    = 8,
   parameter int WINDOW      = 8,
   parameter int STEP        = 16,
   parameter int DECAY_SHIFT = 1,
   parameter int W_INIT      = 32,
   localparam int AW         = (N_PRE > 1) ? $clog2(N_PRE) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        learn_en,
   input  logic [N_PRE-1:0]            pre_spike,
   input  logic                        post_spike,
   input  logic                        wr_en,
   input  logic [AW-1:0]               wr_addr,
   input  logic [WEIGHT_W-1:0]         wr_data,
   output logic [N_PRE*WEIGHT_W-1:0]   weights,
   output logic [N_PRE*TIMER_W-1:0]    pre_age,
   output logic [TIMER_W-1:0]          post_age,
   output logic                        update_valid,
   output logic [N_PRE-1:0]            ltp_mask,
   output logic [N_PRE-1:0]            ltd_mask
);

   localparam logic [WEIGHT_W-1:0] WMAX     = '1;
   localparam logic [TIMER_W-1:0]  STALE    = '1;
   localparam logic [WEIGHT_W-1:0] STEP_V   = WEIGHT_W'(STEP);
   localparam logic [TIMER_W-1:0]  WINDOW_V = TIMER_W'(WINDOW);
   localparam logic [WEIGHT_W-1:0] INIT_V   = WEIGHT_W'(W_INIT);

   logic [TIMER_W-1:0]  pre_age_q [N_PRE];
   logic [TIMER_W-1:0]  post_age_q;
   logic [WEIGHT_W-1:0] w_q [N_PRE];
   logic [WEIGHT_W-1:0] w_d [N_PRE];
   logic [N_PRE-1:0]    ltp_d;
   logic [N_PRE-1:0]    ltd_d;
   logic [N_PRE-1:0]    ltp_q;
   logic [N_PRE-1:0]    ltd_q;
   logic                update_valid_q;

   // An age of zero never occurs after reset; all-ones means stale
   function automatic logic age_ok(input logic [TIMER_W-1:0] a);
      return (a != '0) && (a <= WINDOW_V);
   endfunction

   // Step size halves every 2^DECAY_SHIFT cycles of age, starting at age 1
   function automatic logic [WEIGHT_W-1:0] step_for(input logic [TIMER_W-1:0] a);
      logic [TIMER_W-1:0] sh;
      sh = (a - TIMER_W'(1)) >> DECAY_SHIFT;
      return STEP_V >> sh;
   endfunction

   // Timer advance: reload to 1 on a spike, otherwise count up and stick at stale
   function automatic logic [TIMER_W-1:0] tick(input logic spike, input logic [TIMER_W-1:0] a);
      if (spike)
         return TIMER_W'(1);
      else if (a == STALE)
         return STALE;
      else
         return a + TIMER_W'(1);
   endfunction

   function automatic logic [WEIGHT_W-1:0] sat_add(input logic [WEIGHT_W-1:0] w,
                                                   input logic [WEIGHT_W-1:0] d);
      logic [WEIGHT_W:0] sum;
      sum = {1'b0, w} + {1'b0, d};
      return sum[WEIGHT_W] ? WMAX : sum[WEIGHT_W-1:0];
   endfunction

   function automatic logic [WEIGHT_W-1:0] sat_sub(input logic [WEIGHT_W-1:0] w,
                                                   input logic [WEIGHT_W-1:0] d);
      return (d > w) ? '0 : (w - d);
   endfunction

   // Spike-age timers run every cycle regardless of learn_en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_PRE; i++) pre_age_q[i] <= STALE;
         post_age_q <= STALE;
      end else begin
         for (int i = 0; i < N_PRE; i++) pre_age_q[i] <= tick(pre_spike[i], pre_age_q[i]);
         post_age_q <= tick(post_spike, post_age_q);
      end
   end

   // Next weights from pre-load timer values; a host write overrides learning on its channel
   always_comb begin
      for (int i = 0; i < N_PRE; i++) begin
         w_d[i]   = w_q[i];
         ltp_d[i] = 1'b0;
         ltd_d[i] = 1'b0;
         if (learn_en && post_spike && !pre_spike[i] && age_ok(pre_age_q[i])) begin
            w_d[i]   = sat_add(w_q[i], step_for(pre_age_q[i]));
            ltp_d[i] = (w_d[i] != w_q[i]);
         end else if (learn_en && pre_spike[i] && !post_spike && age_ok(post_age_q)) begin
            w_d[i]   = sat_sub(w_q[i], step_for(post_age_q));
            ltd_d[i] = (w_d[i] != w_q[i]);
         end
         if (wr_en && (int'(wr_addr) == i)) begin
            w_d[i]   = wr_data;
            ltp_d[i] = 1'b0;
            ltd_d[i] = 1'b0;
         end
      end
   end

   // Weight array and one-cycle update flags; masks are zero whenever nothing changed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_PRE; i++) w_q[i] <= INIT_V;
         ltp_q          <= '0;
         ltd_q          <= '0;
         update_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_PRE; i++) w_q[i] <= w_d[i];
         ltp_q          <= ltp_d;
         ltd_q          <= ltd_d;
         update_valid_q <= |{ltp_d, ltd_d};
      end
   end

   for (genvar g = 0; g < N_PRE; g++) begin : g_pack
      assign weights[g*WEIGHT_W +: WEIGHT_W] = w_q[g];
      assign pre_age[g*TIMER_W +: TIMER_W]   = pre_age_q[g];
   end

   assign post_age     = post_age_q;
   assign update_valid = update_valid_q;
   assign ltp_mask     = ltp_q;
   assign ltd_mask     = ltd_q;

endmodule
